// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID->EX stall/flush sequencer for load-use, redirect and iterative divide.
// Optional HAZARD_PERF_CNT_EN builds a 32-bit stall_pc cycle counter on stall_cycles.
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int WIDTH_REGMARK = 5,
    parameter int DIV_CYCLES    = 33,
    parameter int CNT_W         = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_is_div,
    input  logic [WIDTH_REGMARK-1:0] id_rs1,
    input  logic [WIDTH_REGMARK-1:0] id_rs2,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic                     ex_is_load,
    input  logic                     ex_regwe,
    input  logic [WIDTH_REGMARK-1:0] ex_rd,
    input  logic                     ex_redirect,
    input  logic                     div_done,
    output logic                     stall_pc,
    output logic                     stall_if_id,
    output logic                     flush_if_id,
    output logic                     stop_ID,
    output logic                     inst_div,
    output logic                     div_start,
    output logic                     div_busy,
    output logic [31:0]              stall_cycles
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } state_t;

    // Last watchdog value before the count would reach DIV_CYCLES+2.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(DIV_CYCLES + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wd, wd_nxt;
    logic             lu_hazard;
    logic             stall_pc_c, stall_if_id_c, flush_c, stop_c;
    logic             inst_div_c, div_start_c, div_busy_c;

    assign lu_hazard = ex_is_load && ex_regwe && (ex_rd != '0) && id_valid &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        state_nxt     = state;
        wd_nxt        = wd;
        stall_pc_c    = 1'b0;
        stall_if_id_c = 1'b0;
        flush_c       = 1'b0;
        stop_c        = 1'b0;
        inst_div_c    = 1'b0;
        div_start_c   = 1'b0;
        div_busy_c    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_redirect) begin
                    flush_c = 1'b1;
                    stop_c  = 1'b1;
                end else if (lu_hazard) begin
                    stall_pc_c    = 1'b1;
                    stall_if_id_c = 1'b1;
                    stop_c        = 1'b1;
                end else if (id_valid && id_is_div) begin
                    inst_div_c    = 1'b1;
                    div_start_c   = 1'b1;
                    stall_pc_c    = 1'b1;
                    stall_if_id_c = 1'b1;
                    state_nxt     = DIV_RUN;
                    wd_nxt        = '0;
                end
            end
            DIV_RUN: begin
                // EX is occupied by the divide, so redirects cannot occur here.
                div_busy_c    = 1'b1;
                stall_pc_c    = 1'b1;
                stall_if_id_c = 1'b1;
                stop_c        = 1'b1;
                wd_nxt        = wd + 1'b1;
                if (div_done || (wd == WD_LAST)) begin
                    state_nxt = IDLE;
                    wd_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                wd_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    // Outputs are combinational, so gate them to keep them quiet during reset.
    assign stall_pc    = rst_n && stall_pc_c;
    assign stall_if_id = rst_n && stall_if_id_c;
    assign flush_if_id = rst_n && flush_c;
    assign stop_ID     = rst_n && stop_c;
    assign inst_div    = rst_n && inst_div_c;
    assign div_start   = rst_n && div_start_c;
    assign div_busy    = rst_n && div_busy_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (stall_pc) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire
